// File: rtl/serial_addsub16_pkg.sv
// Shared constants for the bit-serial adder/subtractor: state codes,
// default width and counter sizing.
package addsub_pkg;

  localparam int ADDSUB_W = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int ADDSUB_CNT_W = $clog2(ADDSUB_W);

  // Counter width for an arbitrary WIDTH; never narrower than one bit.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_addsub16_if.sv
// Operand/result bus for serial_addsub16: start/busy/done handshake plus
// operands, result and flag set.
interface serial_addsub16_if
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_W
) ();

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] z;
  logic             s;
  logic             zr;
  logic             p;
  logic             cy;
  logic             of;

  modport master (
    output start, sub, x, y,
    input  busy, done, z, s, zr, p, cy, of
  );

  modport slave (
    input  start, sub, x, y,
    output busy, done, z, s, zr, p, cy, of
  );

endinterface

// File: rtl/serial_addsub16_fa_bit.sv
// One-bit full adder with its carry flop; the flop loads the initial
// carry (0 for add, 1 for subtract) when an operation is accepted.
module serial_fa_bit
  import addsub_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic load_val,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);

  logic carry;

  assign sum  = a ^ b ^ carry;
  assign cout = (a & b) | (a & carry) | (b & carry);

  always_ff @(posedge clk) begin
    if (rst)       carry <= 1'b0;
    else if (load) carry <= load_val;
    else if (en)   carry <= cout;
  end

endmodule

// File: rtl/serial_addsub16.sv
// Bit-serial add/subtract, LSB first, one bit per clock; result and
// flags are captured on the last bit step and held until the next one.
module serial_addsub16
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_W
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_addsub16_if.slave     bus
);

  localparam int CW = cnt_w(WIDTH);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] xs, ys, z_sr, z_r, z_next;
  logic             sub_r, xm, ym;
  logic             cy_r, of_r, flags_valid;
  logic             accept, last, run;
  logic             sum_bit, cout;

  assign run    = (state == RUN);
  assign accept = ((state == IDLE) || (state == DONE)) && bus.start;
  assign last   = run && (cnt == CW'(WIDTH - 1));
  assign z_next = {sum_bit, z_sr[WIDTH-1:1]};

  serial_fa_bit u_fa (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (bus.sub),
    .en       (run),
    .a        (xs[0]),
    .b        (ys[0]),
    .sum      (sum_bit),
    .cout     (cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      xs          <= '0;
      ys          <= '0;
      z_sr        <= '0;
      z_r         <= '0;
      sub_r       <= 1'b0;
      xm          <= 1'b0;
      ym          <= 1'b0;
      cy_r        <= 1'b0;
      of_r        <= 1'b0;
      flags_valid <= 1'b0;
    end else if (accept) begin
      // Subtraction is X + ~Y + 1: Y is inverted here, the +1 is the carry load.
      state <= RUN;
      xs    <= bus.x;
      ys    <= bus.sub ? ~bus.y : bus.y;
      z_sr  <= '0;
      cnt   <= '0;
      sub_r <= bus.sub;
      xm    <= bus.x[WIDTH-1];
      ym    <= bus.y[WIDTH-1];
    end else if (run) begin
      xs   <= xs >> 1;
      ys   <= ys >> 1;
      z_sr <= z_next;
      cnt  <= cnt + 1'b1;
      if (last) begin
        state       <= DONE;
        z_r         <= z_next;
        cy_r        <= cout;
        of_r        <= (xm == (ym ^ sub_r)) && (z_next[WIDTH-1] != xm);
        flags_valid <= 1'b1;
      end
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end

  // zr and p stay 0 after reset until a result has actually been produced.
  assign bus.busy = run;
  assign bus.done = (state == DONE);
  assign bus.z    = z_r;
  assign bus.s    = z_r[WIDTH-1];
  assign bus.zr   = flags_valid & ~(|z_r);
  assign bus.p    = flags_valid & ~(^z_r);
  assign bus.cy   = cy_r;
  assign bus.of   = of_r;

endmodule

// File: tb/tb_serial_addsub16.sv
// Self-checking bench for serial_addsub16: directed vector table, hand-built
// handshake corner cases and randomized operations against an arithmetic model.
module tb_serial_addsub16;
  import addsub_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;

  serial_addsub16_if #(.WIDTH(W)) bus ();

  serial_addsub16 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          sub;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [W-1:0]  z;
    logic          s;
    logic          zr;
    logic          p;
    logic          cy;
    logic          of;
  } vec_t;

  int total = 0;
  int bad   = 0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endfunction

  // Reference: signed/unsigned integer arithmetic, no bit-level carry chain.
  function automatic vec_t model(logic sub, logic [W-1:0] x, logic [W-1:0] y);
    vec_t v;
    int sx, sy, r;
    int unsigned ux, uy;
    sx = int'($signed(x));
    sy = int'($signed(y));
    ux = int'(x);
    uy = int'(y);
    r  = sub ? (sx - sy) : (sx + sy);
    v.sub = sub;
    v.x   = x;
    v.y   = y;
    v.z   = W'(r);
    v.s   = v.z[W-1];
    v.zr  = (v.z == '0);
    v.p   = ($countones(v.z) % 2 == 0);
    v.cy  = sub ? (ux >= uy) : ((ux + uy) > 32'hFFFF);
    v.of  = (r > 32767) || (r < -32768);
    return v;
  endfunction

  function automatic void check_out(string tag, vec_t v);
    check({tag, ".z"},  32'(bus.z),  32'(v.z));
    check({tag, ".s"},  32'(bus.s),  32'(v.s));
    check({tag, ".zr"}, 32'(bus.zr), 32'(v.zr));
    check({tag, ".p"},  32'(bus.p),  32'(v.p));
    check({tag, ".cy"}, 32'(bus.cy), 32'(v.cy));
    check({tag, ".of"}, 32'(bus.of), 32'(v.of));
    check({tag, ".busy_done"}, 32'({bus.busy, bus.done}), 32'(2'b01));
  endfunction

  task automatic issue(logic sub, logic [W-1:0] x, logic [W-1:0] y);
    @(negedge clk);
    bus.start = 1'b1;
    bus.sub   = sub;
    bus.x     = x;
    bus.y     = y;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.sub   = 1'($urandom);
    bus.x     = W'($urandom);
    bus.y     = W'($urandom);
  endtask

  // Called #1 after the accepting edge; counts edges until done is seen.
  task automatic wait_done(output int edges, output int busy_n, output bit held);
    logic [W-1:0] z0;
    edges  = 0;
    busy_n = 0;
    held   = 1'b1;
    z0     = bus.z;
    while (!bus.done && edges < 40) begin
      if (bus.busy) busy_n++;
      if (bus.z !== z0) held = 1'b0;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic apply(string tag, vec_t v);
    int edges, busy_n;
    bit held;
    issue(v.sub, v.x, v.y);
    wait_done(edges, busy_n, held);
    check({tag, ".latency"}, 32'(edges), 32'd16);
    check({tag, ".busy_cycles"}, 32'(busy_n), 32'd16);
    check({tag, ".z_held"}, 32'(held), 32'd1);
    check_out(tag, v);
    @(posedge clk);
    #1;
    check({tag, ".done_pulse"}, 32'({bus.busy, bus.done}), 32'd0);
  endtask

  vec_t vecs[5];

  initial begin
    int edges, busy_n;
    bit held;
    vec_t v;

    vecs[0] = '{1'b0, 16'h8fff, 16'h8000, 16'h0fff, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 16'hfffe, 16'h0002, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 16'haaaa, 16'h5555, 16'hffff, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 16'h0001, 16'h0002, 16'hffff, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'h8000, 16'h0001, 16'h7fff, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset.outs", 32'({bus.busy, bus.done, bus.s, bus.zr, bus.p, bus.cy, bus.of}), 32'd0);
    check("reset.z", 32'(bus.z), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) apply($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back: start held high, second op accepted in the DONE cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.sub = 1'b0; bus.x = 16'h0003; bus.y = 16'h0004;
    @(posedge clk);
    #1;
    bus.sub = 1'b1; bus.x = 16'h0010; bus.y = 16'h0001;
    wait_done(edges, busy_n, held);
    check("b2b.first_latency", 32'(edges), 32'd16);
    check_out("b2b.first", model(1'b0, 16'h0003, 16'h0004));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("b2b.busy_after_accept", 32'({bus.busy, bus.done}), 32'(2'b10));
    wait_done(edges, busy_n, held);
    check("b2b.done_spacing", 32'(edges + 1), 32'd17);
    check_out("b2b.second", model(1'b1, 16'h0010, 16'h0001));

    // Start pulsed mid-RUN with new operands is ignored.
    issue(1'b0, 16'h1234, 16'h4321);
    edges = 0;
    busy_n = 0;
    while (!bus.done && edges < 40) begin
      if (edges == 5) begin
        bus.start = 1'b1; bus.sub = 1'b1; bus.x = 16'hffff; bus.y = 16'h0f0f;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.busy) busy_n++;
      @(posedge clk);
      #1;
      edges++;
    end
    bus.start = 1'b0;
    check("ignore.latency", 32'(edges), 32'd16);
    check("ignore.busy_cycles", 32'(busy_n), 32'd16);
    check_out("ignore", model(1'b0, 16'h1234, 16'h4321));

    // Reset mid-RUN, with start asserted on the same edge; reset wins.
    issue(1'b0, 16'hffff, 16'h0001);
    repeat (7) @(posedge clk);
    #1;
    check("abort.busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1; bus.start = 1'b1; bus.x = 16'h00ff; bus.y = 16'h00ff;
    @(posedge clk);
    #1;
    rst = 1'b0; bus.start = 1'b0;
    check("abort.outs", 32'({bus.busy, bus.done, bus.s, bus.zr, bus.p, bus.cy, bus.of}), 32'd0);
    check("abort.z", 32'(bus.z), 32'd0);
    @(posedge clk);
    #1;
    check("abort.stays_idle", 32'({bus.busy, bus.done}), 32'd0);
    apply("after_abort", model(1'b0, 16'h1234, 16'h1111));

    for (int i = 0; i < 40; i++) begin
      v = model(1'($urandom), W'($urandom), W'($urandom));
      apply($sformatf("rand%0d", i), v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_addsub16.md
Name: serial_addsub16

Overview:
Bit-serial 16-bit adder/subtractor. It produces the same result and flag set (Z, S, ZR, P, CY, OF) as the combinational alu, one bit per clock, LSB first.
- It serves as the low-area counterpart of the alu.
- It adds the subtract direction (X − Y), which the alu lacks.
- Operands and results move through a start/busy/done handshake, so a controller can issue operations and collect flags.

Parameters:
- WIDTH, 16, operand/result width in bits. Flags are defined on bit WIDTH-1 and the full result.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request a new operation; sampled only when accepting (IDLE or DONE).
- sub  in  1  operation select, sampled with start: 0 = X+Y, 1 = X−Y.
- x  in  WIDTH  operand X, sampled with start.
- y  in  WIDTH  operand Y, sampled with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result and flags are valid.
- z  out  WIDTH  result.
- s  out  1  sign flag, equal to z[WIDTH-1].
- zr  out  1  zero flag, 1 when z == 0.
- p  out  1  even parity, equal to ~^z (1 when z has an even count of ones).
- cy  out  1  raw carry-out of bit WIDTH-1. For sub, 1 = no borrow.
- of  out  1  two's-complement signed overflow.

Behaviour:
- Reset:
  - state = IDLE.
  - busy = 0, done = 0.
  - z = 0, s = 0, zr = 0, p = 0, cy = 0, of = 0.
  - Bit counter, internal shift registers and carry all cleared.
- States:
  - IDLE: waits for start.
  - RUN: performs WIDTH bit steps.
  - DONE: one cycle; done = 1.
- Transitions:
  - IDLE, start = 1 → RUN.
  - RUN, counter == WIDTH-1 → DONE.
  - DONE, start = 1 → RUN. This allows back-to-back operation.
  - DONE, start = 0 → IDLE.
- Accept, on the edge where start = 1 in IDLE or DONE:
  - Latch x into shift register xs.
  - Latch (sub ? ~y : y) into shift register ys.
  - Carry = sub. This realises subtraction as X + ~Y + 1.
  - Counter = 0.
  - Record sub, x[WIDTH-1] and y[WIDTH-1] for the overflow calculation.
- RUN, each edge:
  - sum bit = xs[0] ^ ys[0] ^ carry.
  - Shift sum into z_sr from the MSB side.
  - carry ← majority(xs[0], ys[0], carry).
  - Shift xs and ys right by 1.
  - counter + 1.
- Latency:
  - Start sampled at edge T gives done = 1 in the cycle following edge T + WIDTH.
  - That is 17 cycles from start to done for WIDTH = 16.
- Result update, on the final RUN edge (transition into DONE):
  - z ← final shifted value.
  - cy ← final carry.
  - s, zr and p are derived from the final z.
  - of = (xm == ym_eff) & (z[WIDTH-1] != xm), where ym_eff = ym ^ sub.
  - z and all flags hold their value until the next completion or rst. They do not change during RUN.
- start while in RUN: ignored. No abort; operands and sub stay as latched.
- x, y and sub may change freely when not being sampled.
- rst mid-RUN: the operation is discarded, state returns to IDLE, and outputs go to their reset values on that edge.
- rst and start on the same edge: rst wins.
- Wrap-around: the sum is modulo 2^WIDTH. The carry is reported only in cy.
- busy and done are never high together.

Decomposition:
- Shared package addsub_pkg holds:
  - the state encoding IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  - the default width constant ADDSUB_W = 16;
  - the counter width, $clog2(WIDTH).
- One natural sub-module: serial_fa_bit.
  - It contains the 1-bit full adder and the carry flop.
  - Its carry flop takes a synchronous load of the initial carry.
  - It has its own rst.
- Flag derivation stays in the top level as combinational logic on the held z.

Test Plan:
1. Add, X = 8fff, Y = 8000 → after 17 cycles done = 1 for one cycle; z = 0fff, s = 0, zr = 0, p = 1, cy = 1, of = 1.
2. Add, X = fffe, Y = 0002 → z = 0000, zr = 1, cy = 1, of = 0, p = 1, s = 0. Then add X = aaaa, Y = 5555 → z = ffff, s = 1, cy = 0, of = 0, p = 1.
3. Sub, X = 0001, Y = 0002 → z = ffff, cy = 0 (borrow), s = 1, of = 0. Then sub X = 8000, Y = 0001 → z = 7fff, of = 1, cy = 1, p = 0.
4. Start held high across two operations (0003+0004, then 0010−0001) → second accepted in the DONE cycle; z = 0007 then 000f; done pulses exactly 17 cycles apart.
5. Pulse start with new operands at RUN cycle 5 → ignored; the result matches the originally latched operation; busy stays high for 16 cycles.
6. Assert rst at RUN cycle 8 → next cycle busy = 0, done = 0, z = 0, all flags 0. A new start then completes normally (1234+1111 → 2345, cy = 0, of = 0).
